// File: rtl/alu_secuencial_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_secuencial_if
// Description : Operand/control and result/status bundle between the load
//               register, the sequential ALU and the display stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_secuencial_if #(
    parameter int N = 4
);
    logic [N-1:0]   Z_m;
    logic [N-1:0]   Y_m;
    logic [1:0]     mode_m;
    logic [1:0]     btn_change_m;
    logic [2*N-1:0] res;
    logic           busy;
    logic           done;
    logic           carry;
    logic           zero;
    logic           div0;

    modport master (
        output Z_m,
        output Y_m,
        output mode_m,
        output btn_change_m,
        input  res,
        input  busy,
        input  done,
        input  carry,
        input  zero,
        input  div0
    );

    modport slave (
        input  Z_m,
        input  Y_m,
        input  mode_m,
        input  btn_change_m,
        output res,
        output busy,
        output done,
        output carry,
        output zero,
        output div0
    );
endinterface
`default_nettype wire

// File: rtl/alu_secuencial.sv
`default_nettype none
// ============================================================================
// Module      : alu_secuencial
// Description : Sequential ALU: single-cycle add/sub, N-cycle shift-add
//               multiply and restoring divide. Status flags built only when
//               ALU_FLAGS_EN is defined; otherwise tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_secuencial #(
    parameter int N = 4
) (
    input  wire logic       clk,
    input  wire logic       rst,
    alu_secuencial_if.slave bus
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_EXEC = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [1:0] c_OP_ADD = 2'b00;
    localparam logic [1:0] c_OP_SUB = 2'b01;
    localparam logic [1:0] c_OP_MUL = 2'b10;
    localparam logic [1:0] c_OP_DIV = 2'b11;

    localparam int c_STEP_W = (N > 1) ? $clog2(N) : 1;

    logic [1:0]          r_state;
    logic                r_start_prev;
    logic [N-1:0]        r_a;
    logic [N-1:0]        r_b;
    logic [1:0]          r_mode;
    logic [c_STEP_W-1:0] r_step;
    logic [2*N-1:0]      r_acc;
    logic [2*N-1:0]      r_a_sh;
    logic [N-1:0]        r_b_sh;
    logic [2*N-1:0]      r_res;

    logic                w_start_edge;
    logic                w_clear;
    logic                w_last;
    logic                w_b_zero;
    logic [N:0]          w_add_sum;
    logic [N-1:0]        w_sub_low;
    logic [2*N-1:0]      w_mul_acc;
    logic [N:0]          w_div_sh;
    logic                w_div_ge;
    logic [N-1:0]        w_div_rem;
    logic [2*N-1:0]      w_div_next;
    logic [2*N-1:0]      w_exec_res;
    logic                w_exec_fin;

    assign w_start_edge = bus.btn_change_m[0] & ~r_start_prev;
    assign w_clear      = bus.btn_change_m[1];
    assign w_last       = (r_step == c_STEP_W'(N - 1));
    assign w_b_zero     = (r_b == '0);

    assign w_add_sum = {1'b0, r_a} + {1'b0, r_b};
    assign w_sub_low = r_a - r_b;

    // Shift-add: r_a_sh holds the multiplicand already aligned to the current bit.
    assign w_mul_acc = r_acc + (r_b_sh[0] ? r_a_sh : '0);

    // Restoring divide: r_acc = {remainder, dividend/quotient}; shift one bit
    // of the dividend into the remainder and try subtracting the divisor.
    assign w_div_sh   = r_acc[2*N-1:N-1];
    assign w_div_ge   = (w_div_sh >= {1'b0, r_b});
    assign w_div_rem  = w_div_ge ? (w_div_sh[N-1:0] - r_b) : w_div_sh[N-1:0];
    assign w_div_next = {w_div_rem, r_acc[N-2:0], w_div_ge};

    always_comb begin
        w_exec_res = '0;
        w_exec_fin = 1'b0;
        case (r_mode)
            c_OP_ADD: begin
                w_exec_res = {{(N-1){1'b0}}, w_add_sum};
                w_exec_fin = 1'b1;
            end
            c_OP_SUB: begin
                w_exec_res = {{N{1'b0}}, w_sub_low};
                w_exec_fin = 1'b1;
            end
            c_OP_MUL: begin
                w_exec_res = w_mul_acc;
                w_exec_fin = w_last;
            end
            default: begin
                if (w_b_zero) begin
                    w_exec_res = '1;
                    w_exec_fin = 1'b1;
                end else begin
                    w_exec_res = w_div_next;
                    w_exec_fin = w_last;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= c_IDLE;
            r_start_prev <= 1'b0;
            r_a          <= '0;
            r_b          <= '0;
            r_mode       <= c_OP_ADD;
            r_step       <= '0;
            r_acc        <= '0;
            r_a_sh       <= '0;
            r_b_sh       <= '0;
            r_res        <= '0;
        end else begin
            r_start_prev <= bus.btn_change_m[0];
            case (r_state)
                c_IDLE: begin
                    if (w_start_edge) begin
                        r_a     <= bus.Z_m;
                        r_b     <= bus.Y_m;
                        r_mode  <= bus.mode_m;
                        r_step  <= '0;
                        r_acc   <= (bus.mode_m == c_OP_DIV) ? {{N{1'b0}}, bus.Z_m} : '0;
                        r_a_sh  <= {{N{1'b0}}, bus.Z_m};
                        r_b_sh  <= bus.Y_m;
                        r_state <= c_EXEC;
                    end else if (w_clear) begin
                        r_res <= '0;
                    end
                end
                c_EXEC: begin
                    if (w_exec_fin) begin
                        r_res   <= w_exec_res;
                        r_state <= c_DONE;
                    end else begin
                        r_step <= r_step + 1'b1;
                        r_acc  <= (r_mode == c_OP_MUL) ? w_mul_acc : w_div_next;
                        r_a_sh <= {r_a_sh[2*N-2:0], 1'b0};
                        r_b_sh <= {1'b0, r_b_sh[N-1:1]};
                    end
                end
                c_DONE: begin
                    // A start edge here is deliberately dropped.
                    if (w_clear) begin
                        r_res <= '0;
                    end
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

`ifdef ALU_FLAGS_EN
    logic r_carry;
    logic r_zero;
    logic r_div0;
    logic w_exec_carry;
    logic w_exec_div0;

    always_comb begin
        w_exec_carry = 1'b0;
        w_exec_div0  = 1'b0;
        case (r_mode)
            c_OP_ADD: w_exec_carry = w_add_sum[N];
            c_OP_SUB: w_exec_carry = (r_a < r_b);
            c_OP_DIV: w_exec_div0  = w_b_zero;
            default:  w_exec_carry = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_carry <= 1'b0;
            r_zero  <= 1'b0;
            r_div0  <= 1'b0;
        end else begin
            if (((r_state == c_IDLE) && !w_start_edge && w_clear) ||
                ((r_state == c_DONE) && w_clear)) begin
                r_carry <= 1'b0;
                r_zero  <= 1'b0;
                r_div0  <= 1'b0;
            end else if ((r_state == c_EXEC) && w_exec_fin) begin
                r_carry <= w_exec_carry;
                r_zero  <= (w_exec_res == '0);
                r_div0  <= w_exec_div0;
            end
        end
    end

    assign bus.carry = r_carry;
    assign bus.zero  = r_zero;
    assign bus.div0  = r_div0;
`else
    assign bus.carry = 1'b0;
    assign bus.zero  = 1'b0;
    assign bus.div0  = 1'b0;
`endif

    assign bus.res  = r_res;
    assign bus.busy = (r_state == c_EXEC);
    assign bus.done = (r_state == c_DONE);

endmodule
`default_nettype wire

// File: tb/tb_alu_secuencial.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_secuencial
// Description : Directed self-checking bench for alu_secuencial (N=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_secuencial;

`ifdef ALU_FLAGS_EN
    localparam logic c_FLAGS = 1'b1;
`else
    localparam logic c_FLAGS = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    alu_secuencial_if #(.N(4)) u_if ();

    alu_secuencial #(.N(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_flags(input string tag, input logic ec, input logic ez, input logic ed);
        check({tag, "_carry"}, 32'(u_if.carry), 32'(ec & c_FLAGS));
        check({tag, "_zero"},  32'(u_if.zero),  32'(ez & c_FLAGS));
        check({tag, "_div0"},  32'(u_if.div0),  32'(ed & c_FLAGS));
    endtask

    task automatic run_op(input string tag, input logic [1:0] mode,
                          input logic [3:0] a, input logic [3:0] b, input int lat,
                          input logic [7:0] exp_res, input logic ec,
                          input logic ez, input logic ed);
        int cyc;
        int busy_cnt;
        u_if.Z_m          = a;
        u_if.Y_m          = b;
        u_if.mode_m       = mode;
        u_if.btn_change_m = 2'b01;
        tick();
        busy_cnt = u_if.busy ? 1 : 0;
        u_if.btn_change_m = 2'b00;
        cyc = 0;
        while (!u_if.done && cyc < 40) begin
            tick();
            cyc++;
            if (u_if.busy) busy_cnt++;
        end
        check({tag, "_latency"}, 32'(cyc), 32'(lat));
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(lat));
        check({tag, "_res"}, 32'(u_if.res), 32'(exp_res));
        check_flags(tag, ec, ez, ed);
        tick();
        check({tag, "_done_pulse"}, 32'(u_if.done), 32'd0);
        check({tag, "_idle_busy"}, 32'(u_if.busy), 32'd0);
    endtask

    initial begin
        int pulses;
        n_checks = 0;
        n_fail   = 0;
        rst               = 1'b0;
        u_if.Z_m          = '0;
        u_if.Y_m          = '0;
        u_if.mode_m       = 2'b00;
        u_if.btn_change_m = 2'b00;
        repeat (3) tick();
        check("rst_res",  32'(u_if.res),  32'd0);
        check("rst_busy", 32'(u_if.busy), 32'd0);
        check("rst_done", 32'(u_if.done), 32'd0);
        check_flags("rst", 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();

        run_op("add_9_8",  2'b00, 4'd9,  4'd8, 1, 8'h11, 1'b1, 1'b0, 1'b0);
        run_op("sub_3_5",  2'b01, 4'd3,  4'd5, 1, 8'h0E, 1'b1, 1'b0, 1'b0);
        run_op("sub_5_5",  2'b01, 4'd5,  4'd5, 1, 8'h00, 1'b0, 1'b1, 1'b0);
        run_op("mul_15_15", 2'b10, 4'd15, 4'd15, 4, 8'hE1, 1'b0, 1'b0, 1'b0);
        run_op("mul_3_5",  2'b10, 4'd3,  4'd5, 4, 8'h0F, 1'b0, 1'b0, 1'b0);
        run_op("div_13_4", 2'b11, 4'd13, 4'd4, 4, 8'h13, 1'b0, 1'b0, 1'b0);
        run_op("div_2_7",  2'b11, 4'd2,  4'd7, 4, 8'h20, 1'b0, 1'b0, 1'b0);
        run_op("div_15_1", 2'b11, 4'd15, 4'd1, 4, 8'h0F, 1'b0, 1'b0, 1'b0);
        run_op("div_7_0",  2'b11, 4'd7,  4'd0, 1, 8'hFF, 1'b0, 1'b0, 1'b1);

        // Held start button: exactly one operation
        u_if.Z_m = 4'd9; u_if.Y_m = 4'd8; u_if.mode_m = 2'b00;
        u_if.btn_change_m = 2'b01;
        pulses = 0;
        for (int i = 0; i < 25; i++) begin
            if (i == 20) u_if.btn_change_m = 2'b00;
            tick();
            if (u_if.done) pulses++;
        end
        check("hold_pulses", 32'(pulses), 32'd1);
        check("hold_res", 32'(u_if.res), 32'h11);
        check_flags("hold", 1'b1, 1'b0, 1'b0);

        // Clear in IDLE
        u_if.btn_change_m = 2'b10;
        tick();
        u_if.btn_change_m = 2'b00;
        check("clear_res", 32'(u_if.res), 32'd0);
        check_flags("clear", 1'b0, 1'b0, 1'b0);

        // Start together with clear: start wins
        run_op("add_2_3", 2'b00, 4'd2, 4'd3, 1, 8'h05, 1'b0, 1'b0, 1'b0);
        u_if.Z_m = 4'd1; u_if.Y_m = 4'd1; u_if.mode_m = 2'b00;
        u_if.btn_change_m = 2'b11;
        tick();
        check("startclr_busy", 32'(u_if.busy), 32'd1);
        check("startclr_res_kept", 32'(u_if.res), 32'h05);
        u_if.btn_change_m = 2'b00;
        tick();
        check("startclr_done", 32'(u_if.done), 32'd1);
        check("startclr_res", 32'(u_if.res), 32'h02);
        tick();

        // Reset during the second EXEC cycle of a multiply
        u_if.Z_m = 4'd15; u_if.Y_m = 4'd15; u_if.mode_m = 2'b10;
        u_if.btn_change_m = 2'b01;
        tick();
        u_if.btn_change_m = 2'b00;
        tick();
        check("abort_busy_before", 32'(u_if.busy), 32'd1);
        rst = 1'b0;
        #1;
        check("abort_res",  32'(u_if.res),  32'd0);
        check("abort_busy", 32'(u_if.busy), 32'd0);
        check("abort_done", 32'(u_if.done), 32'd0);
        check_flags("abort", 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        run_op("mul_after_rst", 2'b10, 4'd15, 4'd15, 4, 8'hE1, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
